recon_bitstream_reader: RTL and testbench
=========================================

# recon_bitstream_reader

Memory-to-stream reader for the reconfiguration datapath. It accepts a read descriptor (address, byte length, tag) from the recon controller's DMA descriptor interface. It fetches the bitstream region from memory over the AXI4 read channels (AR/R) in 4 KB-safe INCR bursts and emits the data as a framed AXI-Stream toward the configuration port. It is the read-side counterpart of the stream-to-memory write bridge that stores incoming bitstreams.

## Interface
Parameters:
- DATA_WIDTH, 512, AXI and stream data width in bits; power of two, ≥ 32
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat (BYTES)
- ADDR_WIDTH, 34, AXI address width
- ID_WIDTH, 8, AXI ID width
- LEN_WIDTH, 20, descriptor byte-length width
- TAG_WIDTH, 8, descriptor tag width
- MAX_BURST_LEN, 16, maximum beats per AXI burst; 1..256

Ports:
- s_axis_clk  in  1  single clock for all interfaces
- rst  in  1  reset, synchronous, active-high
- s_axis_read_desc_addr  in  ADDR_WIDTH  start address; must be BYTES-aligned
- s_axis_read_desc_len  in  LEN_WIDTH  byte count
- s_axis_read_desc_tag  in  TAG_WIDTH  request tag
- s_axis_read_desc_valid / s_axis_read_desc_ready  in / out  1  descriptor handshake
- m_axis_read_desc_status_tag  out  TAG_WIDTH  tag of the completed request
- m_axis_read_desc_status_error  out  1  1 = zero length or non-OKAY rresp seen
- m_axis_read_desc_status_valid  out  1  one-cycle completion pulse
- m_axi_arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0], arlock, arcache[3:0], arprot[2:0], arvalid  out; m_axi_arready  in  AXI4 read address channel
- m_axi_rid, rdata, rresp[1:0], rlast, rvalid  in; m_axi_rready  out  AXI4 read data channel
- m_axis_tdata  out  DATA_WIDTH; m_axis_tkeep  out  KEEP_WIDTH; m_axis_tlast, m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tid  out  TAG_WIDTH  output stream

## Operation
- FSM states: IDLE, ADDR, DATA, STATUS.
- IDLE:
  - s_axis_read_desc_ready=1.
  - On handshake, latch addr, len and tag, and compute beats_rem = ceil(len/BYTES).
  - len==0 goes to STATUS with error=1 and generates no AXI traffic. Otherwise go to ADDR.
- ADDR:
  - burst_beats = min(beats_rem, MAX_BURST_LEN, (4096 − addr[11:0])/BYTES).
  - Drive arvalid=1, arlen=burst_beats−1, and arid=0. The remaining AR fields are constant: arsize=log2(BYTES), arburst=INCR, arlock=0, arcache=4'b0011, arprot=3'b010.
  - On arready, go to DATA, advance addr by burst_beats·BYTES, and subtract burst_beats from beats_rem.
- DATA:
  - Pass-through: m_axis_tvalid=rvalid, m_axi_rready=m_axis_tready, tdata=rdata, tid=latched tag.
  - tkeep is all ones, except on the final beat of the descriptor, where tkeep = low (len mod BYTES) bits set (all ones if the remainder is 0).
  - tlast=1 only on the final beat of the descriptor. AXI rlast of intermediate bursts is not forwarded.
  - Any rresp≠OKAY sets a sticky error bit; the data is still forwarded.
  - On an accepted beat with rlast: if beats_rem==0 go to STATUS, else go to ADDR.
- STATUS: pulse status_valid for one cycle with the tag and the error bit, clear the error bit, then go to IDLE.
- Exactly one burst is outstanding at a time. The block does not check rid.

## Timing
- Reset values: desc_ready=0 during rst and 1 in the cycle after; arvalid=0, rready=0, tvalid=0, tlast=0, tkeep=0, status_valid=0, status_error=0; all address/len fields 0; state=IDLE.
- Reset mid-transfer abandons the request immediately and issues no status. The AXI slave must be reset together with this block.
- Descriptor accept → arvalid: 1 cycle. AR handshake → rready eligible: next cycle. Last beat of a descriptor → status_valid: next cycle. STATUS → desc_ready: next cycle.
- arvalid and all AR fields are held stable until arready. tvalid/tdata follow rvalid/rdata combinationally, so stream stalls back-pressure R directly.
- The 4 KB split arithmetic uses addr[11:0]; beats_rem is LEN_WIDTH bits wide; the address wraps at 2^ADDR_WIDTH without detection.
- A descriptor presented outside IDLE waits (ready=0); it is never dropped.

## Structure
- Shared recon package:
  - AXI constants: BURST_INCR, RESP_OKAY, the default arcache/arprot values.
  - The state-encoding localparams.
  - A clog2-based BYTES_LOG2 helper.
- Burst-size computation (min of three terms) goes in the sub-module recon_burst_calc (combinational). The FSM, counters and tkeep generation stay in the top module.

## Test plan
- addr 0x1000, len 64 → one AR with arlen=0, araddr=0x1000; one beat with tkeep all ones, tlast=1; status tag matches, error=0.
- len 100 → 2 beats; last tkeep = 0x0000000F_FFFFFFFF (36 bytes), tlast on beat 2.
- addr 0x0, len 2560, MAX_BURST_LEN 16 → three ARs: arlen 15/15/7 at 0x000/0x400/0x800; 40 beats with a single tlast.
- addr 0xF00, len 512 → two ARs: arlen 3 at 0xF00, then arlen 3 at 0x1000; no 4 KB crossing.
- SLVERR on beat 1 of 3 → all 3 beats delivered, status_error=1. len=0 → no AR, status_error=1 one cycle after accept.
- Random tready toggling plus rst asserted mid-DATA → no beat lost or duplicated before reset; all outputs at reset values the cycle after rst; the next descriptor completes normally.

Source files
------------

// File: rtl/recon_bitstream_reader_pkg.sv
// Shared recon definitions: AXI constants, reader FSM states and the beat-size helper.
package recon_bitstream_reader_pkg;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] ARPROT_DEFAULT  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_STATUS
    } state_t;

    function automatic int unsigned bytes_log2(input int unsigned bytes);
        return $clog2(bytes);
    endfunction

endpackage

// File: rtl/recon_bitstream_reader_burst_calc.sv
// Burst length for the next AR: min of beats remaining, MAX_BURST_LEN and beats left in the 4 KB page.
module recon_burst_calc
    import recon_bitstream_reader_pkg::*;
#(
    parameter int LEN_WIDTH     = 20,
    parameter int BYTES_LOG2    = 6,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [LEN_WIDTH-1:0] beats_rem,
    input  logic [11:0]          addr_low,
    output logic [8:0]           burst_beats
);

    localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
    localparam logic [CW-1:0] MAX_W = CW'(MAX_BURST_LEN);

    logic [12:0]   page_bytes;
    logic [CW-1:0] rem_w;
    logic [CW-1:0] page_w;

    assign page_bytes = 13'd4096 - {1'b0, addr_low};
    assign page_w     = CW'(page_bytes >> BYTES_LOG2);
    assign rem_w      = CW'(beats_rem);

    // Whichever term wins is at most MAX_BURST_LEN (<= 256), so 9 bits always hold it.
    always_comb begin
        burst_beats = '0;
        if ((rem_w <= MAX_W) && (rem_w <= page_w)) begin
            burst_beats = rem_w[8:0];
        end else if (MAX_W <= page_w) begin
            burst_beats = MAX_W[8:0];
        end else begin
            burst_beats = page_w[8:0];
        end
    end

endmodule

// File: rtl/recon_bitstream_reader.sv
// Descriptor-driven AXI4 memory reader emitting a framed AXI-Stream, one burst in flight at a time.
module recon_bitstream_reader
    import recon_bitstream_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 34,
    parameter int ID_WIDTH      = 8,
    parameter int LEN_WIDTH     = 20,
    parameter int TAG_WIDTH     = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  s_axis_clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axis_read_desc_addr,
    input  logic [LEN_WIDTH-1:0]  s_axis_read_desc_len,
    input  logic [TAG_WIDTH-1:0]  s_axis_read_desc_tag,
    input  logic                  s_axis_read_desc_valid,
    output logic                  s_axis_read_desc_ready,

    output logic [TAG_WIDTH-1:0]  m_axis_read_desc_status_tag,
    output logic                  m_axis_read_desc_status_error,
    output logic                  m_axis_read_desc_status_valid,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [TAG_WIDTH-1:0]  m_axis_tid
);

    localparam int B_LOG2 = bytes_log2(KEEP_WIDTH);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   beats_rem;
    logic [B_LOG2-1:0]      len_rem;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   err_q;
    logic [8:0]             burst_beats;
    logic                   desc_hs;
    logic                   ar_hs;
    logic                   beat_hs;
    logic                   final_beat;
    logic [LEN_WIDTH-1:0]   desc_beats;
    logic [KEEP_WIDTH-1:0]  keep_last;
    logic                   unused_rid;

    recon_burst_calc #(
        .LEN_WIDTH     (LEN_WIDTH),
        .BYTES_LOG2    (B_LOG2),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .beats_rem   (beats_rem),
        .addr_low    (addr_q[11:0]),
        .burst_beats (burst_beats)
    );

    // rid is not checked: only one burst is ever outstanding.
    assign unused_rid = ^m_axi_rid;

    assign desc_hs    = s_axis_read_desc_valid && s_axis_read_desc_ready;
    assign ar_hs      = m_axi_arvalid && m_axi_arready;
    assign beat_hs    = (state == ST_DATA) && m_axi_rvalid && m_axis_tready;
    assign final_beat = (beats_rem == '0) && m_axi_rlast;
    assign desc_beats = (s_axis_read_desc_len >> B_LOG2)
                      + LEN_WIDTH'(|s_axis_read_desc_len[B_LOG2-1:0]);
    assign keep_last  = (len_rem == '0) ? '1
                      : ((KEEP_WIDTH'(1) << len_rem) - KEEP_WIDTH'(1));

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arsize  = 3'(B_LOG2);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = ARCACHE_DEFAULT;
    assign m_axi_arprot  = ARPROT_DEFAULT;
    assign m_axis_tid    = tag_q;
    assign m_axis_read_desc_status_tag = tag_q;

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            addr_q    <= '0;
            beats_rem <= '0;
            len_rem   <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (desc_hs) begin
                        addr_q    <= s_axis_read_desc_addr;
                        beats_rem <= desc_beats;
                        len_rem   <= s_axis_read_desc_len[B_LOG2-1:0];
                        tag_q     <= s_axis_read_desc_tag;
                        err_q     <= (s_axis_read_desc_len == '0);
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        addr_q    <= addr_q + (ADDR_WIDTH'(burst_beats) << B_LOG2);
                        beats_rem <= beats_rem - LEN_WIDTH'(burst_beats);
                    end
                end
                ST_DATA: begin
                    if (beat_hs && (m_axi_rresp != RESP_OKAY)) begin
                        err_q <= 1'b1;
                    end
                end
                ST_STATUS: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // beats_rem already excludes the burst in flight, so zero means this burst ends the descriptor.
    always_comb begin
        state_next                    = state;
        s_axis_read_desc_ready        = 1'b0;
        m_axi_arvalid                 = 1'b0;
        m_axi_arlen                   = '0;
        m_axi_rready                  = 1'b0;
        m_axis_tvalid                 = 1'b0;
        m_axis_tdata                  = '0;
        m_axis_tkeep                  = '0;
        m_axis_tlast                  = 1'b0;
        m_axis_read_desc_status_valid = 1'b0;
        m_axis_read_desc_status_error = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axis_read_desc_ready = !rst;
                if (s_axis_read_desc_valid && !rst) begin
                    state_next = (s_axis_read_desc_len == '0) ? ST_STATUS : ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_arlen   = 8'(burst_beats - 9'd1);
                if (m_axi_arready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axis_tvalid = m_axi_rvalid;
                m_axi_rready  = m_axis_tready;
                m_axis_tdata  = m_axi_rdata;
                m_axis_tlast  = final_beat;
                m_axis_tkeep  = final_beat ? keep_last : '1;
                if (beat_hs && m_axi_rlast) begin
                    state_next = (beats_rem == '0) ? ST_STATUS : ST_ADDR;
                end
            end
            ST_STATUS: begin
                m_axis_read_desc_status_valid = 1'b1;
                m_axis_read_desc_status_error = err_q;
                state_next                    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_recon_bitstream_reader.sv
// Scoreboard bench: behavioural AXI4 read slave, expected AR/beat/status queues checked as the DUT emits them.
module tb_recon_bitstream_reader;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int AW = 34;
    localparam int IW = 8;
    localparam int LW = 20;
    localparam int TW = 8;
    localparam int MB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [AW-1:0] s_axis_read_desc_addr = '0;
    logic [LW-1:0] s_axis_read_desc_len = '0;
    logic [TW-1:0] s_axis_read_desc_tag = '0;
    logic          s_axis_read_desc_valid = 1'b0;
    logic          s_axis_read_desc_ready;
    logic [TW-1:0] m_axis_read_desc_status_tag;
    logic          m_axis_read_desc_status_error;
    logic          m_axis_read_desc_status_valid;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready = 1'b0;
    logic [IW-1:0] m_axi_rid = '0;
    logic [DW-1:0] m_axi_rdata = '0;
    logic [1:0]    m_axi_rresp = '0;
    logic          m_axi_rlast = 1'b0;
    logic          m_axi_rvalid = 1'b0;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [TW-1:0] m_axis_tid;

    recon_bitstream_reader #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .ADDR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .LEN_WIDTH     (LW),
        .TAG_WIDTH     (TW),
        .MAX_BURST_LEN (MB)
    ) dut (
        .s_axis_clk                    (clk),
        .rst                           (rst),
        .s_axis_read_desc_addr         (s_axis_read_desc_addr),
        .s_axis_read_desc_len          (s_axis_read_desc_len),
        .s_axis_read_desc_tag          (s_axis_read_desc_tag),
        .s_axis_read_desc_valid        (s_axis_read_desc_valid),
        .s_axis_read_desc_ready        (s_axis_read_desc_ready),
        .m_axis_read_desc_status_tag   (m_axis_read_desc_status_tag),
        .m_axis_read_desc_status_error (m_axis_read_desc_status_error),
        .m_axis_read_desc_status_valid (m_axis_read_desc_status_valid),
        .m_axi_arid                    (m_axi_arid),
        .m_axi_araddr                  (m_axi_araddr),
        .m_axi_arlen                   (m_axi_arlen),
        .m_axi_arsize                  (m_axi_arsize),
        .m_axi_arburst                 (m_axi_arburst),
        .m_axi_arlock                  (m_axi_arlock),
        .m_axi_arcache                 (m_axi_arcache),
        .m_axi_arprot                  (m_axi_arprot),
        .m_axi_arvalid                 (m_axi_arvalid),
        .m_axi_arready                 (m_axi_arready),
        .m_axi_rid                     (m_axi_rid),
        .m_axi_rdata                   (m_axi_rdata),
        .m_axi_rresp                   (m_axi_rresp),
        .m_axi_rlast                   (m_axi_rlast),
        .m_axi_rvalid                  (m_axi_rvalid),
        .m_axi_rready                  (m_axi_rready),
        .m_axis_tdata                  (m_axis_tdata),
        .m_axis_tkeep                  (m_axis_tkeep),
        .m_axis_tlast                  (m_axis_tlast),
        .m_axis_tvalid                 (m_axis_tvalid),
        .m_axis_tready                 (m_axis_tready),
        .m_axis_tid                    (m_axis_tid)
    );

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [TW-1:0] id; } beat_t;
    typedef struct { logic [TW-1:0] tag; logic err; } st_t;
    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; logic [TW-1:0] tag; } desc_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    st_t   exp_st[$];
    desc_t desc_q[$];
    ar_t   bursts[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int arv_cyc = -1;
    int st_cyc = -1;
    int ar_cnt = 0;
    int beat_cnt = 0;
    int last_cnt = 0;
    int st_cnt = 0;
    logic [KW-1:0] last_keep = '0;
    logic          last_st_err = 1'b0;
    logic [20:0]   ar_const = '0;
    logic          rand_ready = 1'b0;
    logic [AW-1:0] err_addr = '1;

    // slave model state
    logic          r_active = 1'b0;
    int            r_left = 0;
    logic [AW-1:0] r_addr = '0;

    // snapshots taken at the falling edge
    logic          s_rst, s_ready, s_arvalid, s_rready, s_tvalid, s_tlast, s_stv, s_ste;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic [KW-1:0] s_tkeep;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = a[31:0] ^ (32'h9E37_0000 + 32'(j));
        return d;
    endfunction

    task automatic push_expect(input logic [AW-1:0] addr, input int len, input logic [TW-1:0] tag);
        int nb;
        int rem;
        int b;
        int page;
        logic [AW-1:0] a;
        logic err;
        nb  = (len + KW - 1) / KW;
        rem = nb;
        a   = addr;
        err = (len == 0);
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / KW;
            b = rem;
            if (b > MB) b = MB;
            if (b > page) b = page;
            exp_ar.push_back('{a, 8'(b - 1)});
            a = a + AW'(b * KW);
            rem -= b;
        end
        for (int i = 0; i < nb; i++) begin
            beat_t e;
            logic [AW-1:0] ba;
            ba     = addr + AW'(i * KW);
            e.data = pat(ba);
            e.last = (i == nb - 1);
            e.id   = tag;
            for (int k = 0; k < KW; k++) e.keep[k] = !e.last || (len % KW == 0) || (k < len % KW);
            if (ba == err_addr) err = 1'b1;
            exp_beat.push_back(e);
        end
        exp_st.push_back('{tag, err});
        desc_q.push_back('{addr, LW'(len), tag});
    endtask

    task automatic tick();
        logic desc_hs, ar_hs, r_hs, t_hs;
        ar_t   ea;
        beat_t eb;
        st_t   es;
        logic [AW-1:0] ar_addr_s;
        logic [7:0]    ar_len_s;
        @(negedge clk);
        s_rst = rst; s_ready = s_axis_read_desc_ready; s_arvalid = m_axi_arvalid;
        s_rready = m_axi_rready; s_tvalid = m_axis_tvalid; s_tlast = m_axis_tlast;
        s_stv = m_axis_read_desc_status_valid; s_ste = m_axis_read_desc_status_error;
        s_araddr = m_axi_araddr; s_arlen = m_axi_arlen; s_tkeep = m_axis_tkeep;
        desc_hs = s_axis_read_desc_valid && s_axis_read_desc_ready;
        ar_hs = m_axi_arvalid && m_axi_arready;
        r_hs  = m_axi_rvalid && m_axi_rready;
        t_hs  = m_axis_tvalid && m_axis_tready;
        ar_addr_s = m_axi_araddr;
        ar_len_s  = m_axi_arlen;
        if (desc_hs) begin
            acc_cyc = cyc;
            arv_cyc = -1;
        end else if (m_axi_arvalid && arv_cyc < 0) begin
            arv_cyc = cyc;
        end
        if (ar_hs) begin
            ar_cnt++;
            total++;
            ar_const = {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot};
            if (exp_ar.size() == 0) begin
                bad++;
                $display("FAIL ar_unexpected: got addr=%h len=%0d, required no AR", m_axi_araddr, m_axi_arlen);
            end else begin
                ea = exp_ar.pop_front();
                if (m_axi_araddr !== ea.addr || m_axi_arlen !== ea.len) begin
                    bad++;
                    $display("FAIL ar: got addr=%h len=%0d, required addr=%h len=%0d",
                             m_axi_araddr, m_axi_arlen, ea.addr, ea.len);
                end
            end
        end
        if (t_hs) begin
            beat_cnt++;
            total++;
            if (m_axis_tlast) begin
                last_cnt++;
                last_keep = m_axis_tkeep;
            end
            if (exp_beat.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got keep=%h last=%b, required no beat", m_axis_tkeep, m_axis_tlast);
            end else begin
                eb = exp_beat.pop_front();
                if (m_axis_tdata !== eb.data || m_axis_tkeep !== eb.keep ||
                    m_axis_tlast !== eb.last || m_axis_tid !== eb.id) begin
                    bad++;
                    $display("FAIL beat: got data=%h keep=%h last=%b id=%h, required data=%h keep=%h last=%b id=%h",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
                             eb.data, eb.keep, eb.last, eb.id);
                end
            end
        end
        if (m_axis_read_desc_status_valid === 1'b1) begin
            st_cnt++;
            st_cyc = cyc;
            last_st_err = m_axis_read_desc_status_error;
            total++;
            if (exp_st.size() == 0) begin
                bad++;
                $display("FAIL status_unexpected: got tag=%h err=%b, required none",
                         m_axis_read_desc_status_tag, m_axis_read_desc_status_error);
            end else begin
                es = exp_st.pop_front();
                if (m_axis_read_desc_status_tag !== es.tag || m_axis_read_desc_status_error !== es.err) begin
                    bad++;
                    $display("FAIL status: got tag=%h err=%b, required tag=%h err=%b",
                             m_axis_read_desc_status_tag, m_axis_read_desc_status_error, es.tag, es.err);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            bursts.delete();
            r_active = 1'b0;
            r_left = 0;
            m_axi_rvalid = 1'b0;
            m_axi_rlast = 1'b0;
            m_axi_arready = 1'b0;
            s_axis_read_desc_valid = 1'b0;
        end else begin
            if (ar_hs) bursts.push_back('{ar_addr_s, ar_len_s});
            if (r_hs) begin
                r_left--;
                r_addr = r_addr + AW'(KW);
                if (r_left == 0) r_active = 1'b0;
            end
            if (!r_active && bursts.size() > 0) begin
                ea = bursts.pop_front();
                r_addr = ea.addr;
                r_left = int'(ea.len) + 1;
                r_active = 1'b1;
            end
            if (!(m_axi_rvalid && !r_hs)) begin
                if (r_active && $urandom_range(3) != 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = pat(r_addr);
                    m_axi_rresp  = (r_addr == err_addr) ? 2'b10 : 2'b00;
                    m_axi_rlast  = (r_left == 1);
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
            m_axi_arready = ($urandom_range(2) != 0);
            if (desc_hs) s_axis_read_desc_valid = 1'b0;
            if (!s_axis_read_desc_valid && desc_q.size() > 0) begin
                desc_t d;
                d = desc_q.pop_front();
                s_axis_read_desc_addr  = d.addr;
                s_axis_read_desc_len   = d.len;
                s_axis_read_desc_tag   = d.tag;
                s_axis_read_desc_valid = 1'b1;
            end
        end
        m_axis_tready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (st_cnt < target && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (st_cnt < target) begin
            bad++;
            $display("FAIL %s_timeout: got %0d statuses, required %0d", name, st_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low: got %b, required 0", s_ready); end
        rst = 1'b0;
        tick();
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b, required 1", s_ready); end
        total++;
        if ({s_arvalid, s_rready, s_tvalid, s_tlast, s_stv, s_ste} !== 6'b0) begin
            bad++;
            $display("FAIL rst_ctrl: got %b, required 000000", {s_arvalid, s_rready, s_tvalid, s_tlast, s_stv, s_ste});
        end
        total++;
        if (s_tkeep !== '0 || s_araddr !== '0 || s_arlen !== '0) begin
            bad++;
            $display("FAIL rst_fields: got keep=%h addr=%h len=%h, required 0", s_tkeep, s_araddr, s_arlen);
        end
    endtask

    task automatic test_single();
        int a0, l0;
        a0 = ar_cnt; l0 = last_cnt;
        push_expect(34'h1000, 64, 8'h11);
        wait_done(st_cnt + 1, 300, "single");
        total++;
        if (arv_cyc !== acc_cyc + 1) begin bad++; $display("FAIL single_ar_latency: got %0d, required %0d", arv_cyc, acc_cyc + 1); end
        total++;
        if (ar_cnt - a0 !== 1 || last_cnt - l0 !== 1) begin bad++; $display("FAIL single_counts: got ar=%0d last=%0d, required 1/1", ar_cnt - a0, last_cnt - l0); end
        total++;
        if (ar_const !== {8'h00, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b010}) begin bad++; $display("FAIL ar_const: got %h, required %h", ar_const, {8'h00, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b010}); end
    endtask

    task automatic test_partial();
        int b0;
        b0 = beat_cnt;
        push_expect(34'h2000, 100, 8'h22);
        wait_done(st_cnt + 1, 300, "partial");
        total++;
        if (last_keep !== 64'h0000000F_FFFFFFFF || beat_cnt - b0 !== 2) begin
            bad++;
            $display("FAIL partial_keep: got keep=%h beats=%0d, required 0000000fffffffff/2", last_keep, beat_cnt - b0);
        end
    endtask

    task automatic test_multi_burst();
        int a0, b0, l0;
        a0 = ar_cnt; b0 = beat_cnt; l0 = last_cnt;
        rand_ready = 1'b1;
        push_expect(34'h0, 2560, 8'h33);
        wait_done(st_cnt + 1, 2000, "multi");
        rand_ready = 1'b0;
        total++;
        if (ar_cnt - a0 !== 3 || beat_cnt - b0 !== 40 || last_cnt - l0 !== 1) begin
            bad++;
            $display("FAIL multi_counts: got ar=%0d beats=%0d last=%0d, required 3/40/1", ar_cnt - a0, beat_cnt - b0, last_cnt - l0);
        end
    endtask

    task automatic test_4k_split();
        int a0;
        a0 = ar_cnt;
        push_expect(34'hF00, 512, 8'h44);
        wait_done(st_cnt + 1, 500, "split4k");
        total++;
        if (ar_cnt - a0 !== 2) begin bad++; $display("FAIL split4k_ars: got %0d, required 2", ar_cnt - a0); end
    endtask

    task automatic test_slverr();
        int b0;
        b0 = beat_cnt;
        err_addr = 34'h3040;
        push_expect(34'h3000, 192, 8'h55);
        wait_done(st_cnt + 1, 500, "slverr");
        err_addr = '1;
        total++;
        if (last_st_err !== 1'b1 || beat_cnt - b0 !== 3) begin
            bad++;
            $display("FAIL slverr: got err=%b beats=%0d, required 1/3", last_st_err, beat_cnt - b0);
        end
    endtask

    task automatic test_zero_len();
        int a0;
        a0 = ar_cnt;
        push_expect(34'h8000, 0, 8'h77);
        wait_done(st_cnt + 1, 50, "zero_len");
        tick();
        total++;
        if (st_cyc !== acc_cyc + 1 || last_st_err !== 1'b1 || ar_cnt !== a0) begin
            bad++;
            $display("FAIL zero_len: got st_cyc=%0d err=%b ars=%0d, required %0d/1/0", st_cyc, last_st_err, ar_cnt - a0, acc_cyc + 1);
        end
    endtask

    task automatic test_back_to_back();
        rand_ready = 1'b1;
        push_expect(34'h4000, 300, 8'h81);
        push_expect(34'h4FC0, 200, 8'h82);
        wait_done(st_cnt + 2, 2000, "back_to_back");
        rand_ready = 1'b0;
        total++;
        if (exp_ar.size() != 0 || exp_beat.size() != 0 || exp_st.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: got ar=%0d beat=%0d st=%0d left, required 0", exp_ar.size(), exp_beat.size(), exp_st.size());
        end
    endtask

    task automatic test_reset_mid();
        int b0, s0, n;
        b0 = beat_cnt; s0 = st_cnt; n = 0;
        rand_ready = 1'b1;
        push_expect(34'h6000, 2048, 8'h99);
        while (beat_cnt - b0 < 5 && n < 500) begin
            tick();
            n++;
        end
        total++;
        if (beat_cnt - b0 < 5) begin bad++; $display("FAIL rstmid_timeout: got %0d beats, required 5", beat_cnt - b0); end
        rst = 1'b1;
        tick();
        exp_ar.delete(); exp_beat.delete(); exp_st.delete(); desc_q.delete();
        rst = 1'b0;
        tick();
        total++;
        if ({s_ready, s_arvalid, s_rready, s_tvalid, s_tlast, s_stv} !== 6'b100000 || s_tkeep !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %b keep=%h, required 100000 keep=0", {s_ready, s_arvalid, s_rready, s_tvalid, s_tlast, s_stv}, s_tkeep);
        end
        repeat (5) tick();
        total++;
        if (st_cnt !== s0) begin bad++; $display("FAIL rstmid_no_status: got %0d, required %0d", st_cnt - s0, 0); end
        rand_ready = 1'b0;
        push_expect(34'h7000, 128, 8'hA0);
        wait_done(st_cnt + 1, 300, "after_reset");
        total++;
        if (exp_beat.size() != 0 || exp_ar.size() != 0) begin
            bad++;
            $display("FAIL after_reset_drain: got beat=%0d ar=%0d left, required 0", exp_beat.size(), exp_ar.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_multi_burst();
        test_4k_split();
        test_slverr();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
